// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches PS2_CLK, shifts in 11-bit frames, hands the byte to a consumer.
// Latency: RXDATA/RXVALID update one CLK after the filtered falling edge of the stop bit (2 sync + FILTER_LEN filter + 1 after the pin edge).
// Backpressure: none toward the keyboard; an unacknowledged byte is overwritten by the next one and OVERRUN is flagged.
// Optional parity enforcement: define PS2_PARITY_CHECK_EN; otherwise the parity bit is captured but ignored and PERR stays 0.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       RDACK,
  input  logic       ERRCLR,
  output logic [7:0] RXDATA,
  output logic       RXVALID,
  output logic       OVERRUN,
  output logic       FERR,
  output logic       PERR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // synchronizer and filter state
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          filt_prev;
  logic          fall_stb;

  // frame state
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  // per-cycle events
  logic          par_ok;
  logic          par_bad;
  logic          stop_stb;
  logic          timeout_hit;
  logic          commit;
  logic          ferr_evt;
  logic          perr_evt;
  logic          ovr_evt;

  // Two-flop synchronizers; reset to 1 so the bus looks idle coming out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  // Deglitch filter: the filtered clock follows only after FILTER_LEN consecutive samples of the new level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // One-cycle strobe on the filtered 1->0 transition.
  assign fall_stb = filt_prev & ~filt_clk;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign par_ok = ^{shreg, par_bit};

`ifdef PS2_PARITY_CHECK_EN
  assign par_bad = ~par_ok;
`else
  // Parity is still captured so the frame format is unchanged, but no decision depends on it.
  logic par_ok_unused;
  assign par_ok_unused = par_ok;
  assign par_bad       = 1'b0;
`endif

  // Decode the frame and error events for this cycle from state, strobe and sampled data.
  always_comb begin
    stop_stb    = 1'b0;
    timeout_hit = 1'b0;
    commit      = 1'b0;
    ferr_evt    = 1'b0;
    perr_evt    = 1'b0;
    ovr_evt     = 1'b0;

    stop_stb    = fall_stb && (state == S_STOP);
    timeout_hit = (state != S_IDLE) && !fall_stb && (to_cnt == TW'(TIMEOUT_CYC - 1));
    commit      = stop_stb && dat_s2 && !par_bad;
    perr_evt    = stop_stb && dat_s2 && par_bad;
    ferr_evt    = timeout_hit
                | (fall_stb && (state == S_IDLE) && dat_s2)
                | (stop_stb && !dat_s2);
    // An acknowledge in the commit cycle consumes the old byte, so the new one is not an overrun.
    ovr_evt     = commit && RXVALID && !RDACK;
  end

  // Frame FSM with registered byte hand-off, sticky error flags and inactivity timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      RXDATA  <= '0;
      RXVALID <= 1'b0;
      OVERRUN <= 1'b0;
      FERR    <= 1'b0;
      PERR    <= 1'b0;
    end else begin
      // Sticky flags: a new error in the same cycle as ERRCLR keeps the flag set.
      OVERRUN <= ovr_evt  | (OVERRUN & ~ERRCLR);
      FERR    <= ferr_evt | (FERR    & ~ERRCLR);
      PERR    <= perr_evt | (PERR    & ~ERRCLR);

      if (commit) begin
        RXDATA  <= shreg;
        RXVALID <= 1'b1;
      end else if (RDACK) begin
        RXVALID <= 1'b0;
      end

      if (state == S_IDLE || fall_stb) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (timeout_hit) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
        to_cnt  <= '0;
      end else if (fall_stb) begin
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          S_STOP: begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
